binary_to_bcd_seq: RTL and testbench
====================================

Name: binary_to_bcd_seq

Overview:
- Sequential double-dabble converter that sits directly upstream of the 8-digit seven-segment display driver.
- Takes a 32-bit unsigned binary value, such as a register, PC or ALU result, and produces 8 packed BCD digits.
- The display then shows decimal instead of hex.
- Uses a start/busy/done handshake so the CPU-side mux can request conversions at any rate; the result is held stable between conversions.

Parameters:
- WIDTH_IN, 32, width of the binary input; also the number of shift iterations.
- DIGITS, 8, number of BCD output digits; output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  conversion request; sampled only when busy=0
- binary  input  WIDTH_IN  unsigned value to convert; sampled in the start cycle only
- busy  output  1  high while a conversion is in progress, through the done cycle inclusive
- done  output  1  one-cycle pulse; bcd/overflow are valid and updated in this cycle
- bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]; held until the next done
- overflow  output  1  high when the last converted value exceeded 10^DIGITS-1; held with bcd

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, shift counter=0, scratch registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: latch binary into shift register; clear BCD scratch; counter=0; compute ovf_pending = (binary > 10^DIGITS-1); go to SHIFT.
- SHIFT, one iteration per cycle:
  - Each scratch nibble >=5 gets +3 (4-bit, no carry between nibbles).
  - Then {scratch, shreg} shifts left by 1; the MSB of shreg enters scratch bit 0.
  - Counter increments; after iteration WIDTH_IN-1 go to DONE.
- DONE, one cycle:
  - done=1.
  - bcd = ovf_pending ? all digits 9 (saturate) : scratch.
  - overflow = ovf_pending.
  - Then go to IDLE.
- Latency: start sampled in cycle N gives SHIFT in cycles N+1..N+WIDTH_IN and done in cycle N+WIDTH_IN+1 (N+33 at default).
- busy=1 from N+1 through the done cycle; busy=0 in IDLE.
- start while busy=1 is ignored (no queueing); binary changes after the start cycle have no effect.
- Back-to-back: start may be asserted the cycle after done (state=IDLE), giving a 34-cycle period.
- Reset mid-conversion: next cycle is IDLE; all outputs are 0 and the partial result is discarded.
- Reset has priority over start in the same cycle.
- Scratch width is 4*DIGITS. Overflow detection uses the input compare only, never scratch bits lost off the top.
- bcd and overflow change only in a done cycle or on reset.

Decomposition:
- Shared package display_pkg holds:
  - DIGITS_DEFAULT=8.
  - BCD_MAX constant (10^DIGITS-1, 32'd99_999_999).
  - BCD_SAT constant (32'h9999_9999).
  - FSM state enum (IDLE, SHIFT, DONE).
- One sub-module, bcd_digit_adjust: combinational 4-bit "add 3 if >=5" cell, instantiated DIGITS times inside the SHIFT datapath.

Test Plan:
- Reset, then start with binary=0 -> done at +33 cycles, bcd=32'h0000_0000, overflow=0.
- binary=32'h00BC_614E (12,345,678) -> bcd=32'h1234_5678, overflow=0, busy high for exactly 33 cycles.
- binary=32'h05F5_E0FF (99,999,999) -> bcd=32'h9999_9999, overflow=0.
- binary=32'h05F5_E100 (100,000,000), then 32'hFFFF_FFFF -> bcd=32'h9999_9999, overflow=1 both times.
- Start binary=1234; in the next cycle assert start with binary=5678 and change binary -> result bcd=32'h0000_1234, second start ignored; a start the cycle after done (binary=5678) converts to 32'h0000_5678.
- Start binary=42; assert reset at cycle +10 -> busy=0, done never pulses, bcd=0; then start binary=42 -> bcd=32'h0000_0042.

Source files
------------

// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the display-side BCD converter.
package display_pkg;

    localparam int          DIGITS_DEFAULT = 8;
    localparam logic [31:0] BCD_MAX        = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT        = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Largest value representable in 'digits' decimal digits; used for non-default widths.
    function automatic logic [63:0] pow10_minus1(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Start/busy/done conversion handshake between the CPU-side mux and the converter.
import display_pkg::*;

interface binary_to_bcd_seq_if #(
    parameter int WIDTH_IN = 32,
    parameter int DIGITS   = DIGITS_DEFAULT
);
    logic                  start;
    logic [WIDTH_IN-1:0]   binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, binary, input busy, done, bcd, overflow);
    modport slave  (input start, binary, output busy, done, bcd, overflow);
endinterface

// File: rtl/binary_to_bcd_seq_digit_adjust.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    // Wraps within 4 bits; carries between digits come only from the following shift.
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle, saturating on overflow.
module binary_to_bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH_IN = 32,
    parameter int DIGITS   = DIGITS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    binary_to_bcd_seq_if.slave conv
);
    localparam int             CNT_W = $clog2(WIDTH_IN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_IN - 1);

    logic [63:0]          max_val;
    logic [4*DIGITS-1:0]  sat_val;

    if (DIGITS == DIGITS_DEFAULT) begin : g_default_consts
        assign max_val = 64'(BCD_MAX);
        assign sat_val = BCD_SAT;
    end else begin : g_general_consts
        assign max_val = pow10_minus1(DIGITS);
        assign sat_val = {DIGITS{4'h9}};
    end

    state_e               state_q, state_d;
    logic [WIDTH_IN-1:0]  shreg_q, shreg_d;
    logic [4*DIGITS-1:0]  scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 overflow_q, overflow_d;

    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  scratch_shift;
    logic [WIDTH_IN-1:0]  shreg_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    assign scratch_shift = {adj[4*DIGITS-2:0], shreg_q[WIDTH_IN-1]};
    assign shreg_shift   = {shreg_q[WIDTH_IN-2:0], 1'b0};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (conv.start) begin
                    shreg_d    = conv.binary;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = 64'(conv.binary) > max_val;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_shift;
                shreg_d   = shreg_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                // Result is registered on the final shift so it is already valid in the done cycle.
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    bcd_d      = ovf_pend_q ? sat_val : scratch_shift;
                    overflow_d = ovf_pend_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign conv.busy     = (state_q != IDLE);
    assign conv.done     = (state_q == DONE);
    assign conv.bcd      = bcd_q;
    assign conv.overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench: stimulus pushes decimal-model expectations, a monitor checks each done pulse.
module tb_binary_to_bcd_seq;

    logic clk;
    logic reset;

    binary_to_bcd_seq_if #(.WIDTH_IN(32), .DIGITS(8)) bus ();

    binary_to_bcd_seq #(.WIDTH_IN(32), .DIGITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .conv  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digits by repeated division, saturate above eight digits.
    function automatic exp_t model(input logic [31:0] v);
        exp_t        e;
        logic [63:0] x;
        logic [31:0] b;
        x = 64'(v);
        b = '0;
        if (x > 64'd99_999_999) begin
            e.bcd = 32'h9999_9999;
            e.ovf = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                b[4*i +: 4] = 4'(x % 64'd10);
                x = x / 64'd10;
            end
            e.bcd = b;
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("done_without_request", bus.done, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("bcd", bus.bcd, e.bcd);
                    check("overflow", bus.overflow, e.ovf);
                    hold_bcd = e.bcd;
                    hold_ovf = e.ovf;
                end
            end else begin
                check("bcd_hold", bus.bcd, hold_bcd);
                check("overflow_hold", bus.overflow, hold_ovf);
            end
        end
    end

    task automatic do_conv(input logic [31:0] v, input bit chk_lat, input bit poke);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        bus.start  = 1'b1;
        bus.binary = v;
        sb_q.push_back(model(v));
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (lat == 1 && poke) begin
                bus.start  = 1'b1;
                bus.binary = 32'd5678;
            end else begin
                bus.start  = 1'b0;
                bus.binary = $urandom;
            end
        end while (!bus.done && lat < 100);
        if (!bus.done) check("done_timeout", bus.done, 1'b1);
        if (chk_lat) begin
            check("latency", lat, 33);
            check("busy_cycles", bcnt, 33);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        sb_q.delete();
        hold_bcd = '0;
        hold_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_bcd", bus.bcd, 32'h0);
        check("rst_overflow", bus.overflow, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.binary = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        apply_reset();

        do_conv(32'd0, 1'b1, 1'b0);
        do_conv(32'h00BC_614E, 1'b1, 1'b0);
        do_conv(32'h05F5_E0FF, 1'b1, 1'b0);
        do_conv(32'h05F5_E100, 1'b1, 1'b0);
        do_conv(32'hFFFF_FFFF, 1'b1, 1'b0);

        // Second start while busy must be ignored; the follow-up start is back-to-back.
        do_conv(32'd1234, 1'b1, 1'b1);
        do_conv(32'd5678, 1'b1, 1'b0);

        // Reset ten cycles into a conversion discards it.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.binary = 32'd42;
        sb_q.push_back(model(32'd42));
        @(negedge clk);
        bus.start  = 1'b0;
        bus.binary = 32'd77;
        repeat (9) @(negedge clk);
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 39) check("idle_after_reset", bus.busy, 1'b0);
        end
        do_conv(32'd42, 1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99_999_999);
                2:       v = 32'd99_999_998 + $urandom_range(0, 3);
                default: v = $urandom_range(0, 9999);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_conv(v, 1'b0, n[0]);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
